// File: rtl/screen_ctrl.sv
// -----------------------------------------------------------------------------
// screen_ctrl
//   Game screen sequencer: MENU -> COUNTDOWN -> PLAY (-> HIT_FLASH) -> GAMEOVER.
//   All state and output updates happen once per frame, on the pclk after
//   frame_tick. Between ticks, start_btn and hit are captured into sticky
//   flags so that short pulses anywhere in a frame are never lost.
//
//   Optional feature macro: HIT_FLASH_EN
//     defined   -> a non-fatal hit enters HIT_FLASH (movement frozen, border
//                  blinks) for FLASH_FRAMES frames, then play resumes.
//     undefined -> a non-fatal hit only decrements lives and play continues;
//                  flash_out is tied low.
//
// Ports
//   pclk          in   pixel clock (single domain)
//   rst           in   asynchronous active-high reset
//   vblnk_in      in   vertical blanking from the timing chain
//   start_btn     in   debounced start request (level)
//   hit           in   player/obstacle collision pulse
//   screen_sel    out  0=MENU 1=COUNTDOWN 2=PLAY/HIT_FLASH 3=GAMEOVER
//   play_en       out  high only in PLAY
//   countdown_out out  seconds remaining in COUNTDOWN, else 0
//   lives_out     out  current lives
//   frame_tick    out  one-pclk pulse per frame
//   flash_out     out  arena border colour (0 white, 1 red)
// -----------------------------------------------------------------------------
module screen_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SECONDS  = 3,
    parameter int LIVES          = 3,
    parameter int FLASH_FRAMES   = 32
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic       start_btn,
    input  logic       hit,
    output logic [1:0] screen_sel,
    output logic       play_en,
    output logic [1:0] countdown_out,
    output logic [1:0] lives_out,
    output logic       frame_tick,
    output logic       flash_out
);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        HIT_FLASH = 3'd3,
        GAMEOVER  = 3'd4
    } state_e;

    localparam logic [5:0] FPS_LAST   = 6'(FRAMES_PER_SEC - 1);
    localparam logic [1:0] COUNT_INIT = 2'(COUNT_SECONDS);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
`ifdef HIT_FLASH_EN
    localparam logic [5:0] FLASH_LAST = 6'(FLASH_FRAMES - 1);
`endif

    // Frame edge detection and sticky input flags
    logic vblnk_q;
    logic frame_tick_q;
    logic start_flag_q;
    logic hit_flag_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            // History starts high so a blanking interval already in progress
            // at reset release does not produce a spurious tick.
            vblnk_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            start_flag_q <= 1'b0;
            hit_flag_q   <= 1'b0;
        end else begin
            vblnk_q      <= vblnk_in;
            frame_tick_q <= vblnk_in & ~vblnk_q;
            // On the tick cycle the flag is consumed; a request arriving on
            // that same cycle reloads it for the following frame.
            start_flag_q <= frame_tick_q ? start_btn : (start_flag_q | start_btn);
            hit_flag_q   <= frame_tick_q ? hit       : (hit_flag_q   | hit);
        end
    end

    // Frame-rate state
    state_e     state_q,      state_d;
    logic [5:0] cnt_q,        cnt_d;
    logic [1:0] countdown_q,  countdown_d;
    logic [1:0] lives_q,      lives_d;
    logic [1:0] screen_sel_q, screen_sel_d;
    logic       play_en_q,    play_en_d;
`ifdef HIT_FLASH_EN
    logic       flash_q,      flash_d;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        countdown_d = countdown_q;
        lives_d     = lives_q;
`ifdef HIT_FLASH_EN
        flash_d     = 1'b0;
`endif

        case (state_q)
            MENU, GAMEOVER: begin
                // lives_out stays at its current value (0 in GAMEOVER) until restart
                if (start_flag_q) begin
                    state_d     = COUNTDOWN;
                    cnt_d       = '0;
                    countdown_d = COUNT_INIT;
                    lives_d     = LIVES_INIT;
                end
            end
            COUNTDOWN: begin
                if (cnt_q == FPS_LAST) begin
                    cnt_d = '0;
                    if (countdown_q == 2'd1) begin
                        state_d     = PLAY;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            PLAY: begin
                // A simultaneous start request is simply not looked at here.
                if (hit_flag_q) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
`ifdef HIT_FLASH_EN
                        state_d = HIT_FLASH;
                        cnt_d   = '0;
`endif
                    end else begin
                        lives_d = '0;
                        state_d = GAMEOVER;
                    end
                end
            end
`ifdef HIT_FLASH_EN
            HIT_FLASH: begin
                // Hits during the flash are ignored; border follows counter bit 2.
                if (cnt_q == FLASH_LAST) begin
                    state_d = PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                    flash_d = cnt_d[2];
                end
            end
`endif
            default: begin
                state_d     = MENU;
                cnt_d       = '0;
                countdown_d = '0;
                lives_d     = LIVES_INIT;
            end
        endcase

        // Outputs follow the state being entered so they are valid together.
        case (state_d)
            COUNTDOWN: screen_sel_d = 2'd1;
            PLAY:      screen_sel_d = 2'd2;
`ifdef HIT_FLASH_EN
            HIT_FLASH: screen_sel_d = 2'd2;
`endif
            GAMEOVER:  screen_sel_d = 2'd3;
            default:   screen_sel_d = 2'd0;
        endcase
        play_en_d = (state_d == PLAY);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= MENU;
            cnt_q        <= '0;
            countdown_q  <= '0;
            lives_q      <= LIVES_INIT;
            screen_sel_q <= '0;
            play_en_q    <= 1'b0;
`ifdef HIT_FLASH_EN
            flash_q      <= 1'b0;
`endif
        end else if (frame_tick_q) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            countdown_q  <= countdown_d;
            lives_q      <= lives_d;
            screen_sel_q <= screen_sel_d;
            play_en_q    <= play_en_d;
`ifdef HIT_FLASH_EN
            flash_q      <= flash_d;
`endif
        end
    end

    assign screen_sel    = screen_sel_q;
    assign play_en       = play_en_q;
    assign countdown_out = countdown_q;
    assign lives_out     = lives_q;
    assign frame_tick    = frame_tick_q;
`ifdef HIT_FLASH_EN
    assign flash_out     = flash_q;
`else
    assign flash_out     = 1'b0;
`endif

endmodule

// File: tb/tb_screen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_screen_ctrl
//   Directed bench for screen_ctrl with FRAMES_PER_SEC=4, COUNT_SECONDS=3,
//   LIVES=3, FLASH_FRAMES=8. Works with or without HIT_FLASH_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_screen_ctrl;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vblnk_in;
    logic       start_btn;
    logic       hit;
    logic [1:0] screen_sel;
    logic       play_en;
    logic [1:0] countdown_out;
    logic [1:0] lives_out;
    logic       frame_tick;
    logic       flash_out;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    screen_ctrl #(
        .FRAMES_PER_SEC(4),
        .COUNT_SECONDS (3),
        .LIVES         (3),
        .FLASH_FRAMES  (8)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .start_btn    (start_btn),
        .hit          (hit),
        .screen_sel   (screen_sel),
        .play_en      (play_en),
        .countdown_out(countdown_out),
        .lives_out    (lives_out),
        .frame_tick   (frame_tick),
        .flash_out    (flash_out)
    );

    always #5 pclk = ~pclk;

    // frame_tick is stable across the falling edge
    always @(negedge pclk) if (frame_tick === 1'b1) tick_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: vblnk low for 2 cycles then rising; ends 3 falling edges
    // after the rise, by which time the frame update is visible.
    task automatic frame();
        @(negedge pclk) vblnk_in = 1'b0;
        repeat (2) @(negedge pclk);
        vblnk_in = 1'b1;
        repeat (3) @(negedge pclk);
    endtask

    // Same frame, but hit is driven during the cycle frame_tick is high.
    task automatic frame_hit_on_tick();
        @(negedge pclk) vblnk_in = 1'b0;
        repeat (2) @(negedge pclk);
        vblnk_in = 1'b1;
        @(negedge pclk);
        check("tick_aligned", 32'(frame_tick), 1);
        hit = 1'b1;
        @(negedge pclk) hit = 1'b0;
        @(negedge pclk);
    endtask

    task automatic pulse_start();
        @(negedge pclk) start_btn = 1'b1;
        @(negedge pclk) start_btn = 1'b0;
    endtask

    task automatic pulse_hit();
        @(negedge pclk) hit = 1'b1;
        @(negedge pclk) hit = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] sel, input logic pe,
                                 input logic [1:0] cd, input logic [1:0] lv);
        check({tag, "_sel"},   32'(screen_sel),    32'(sel));
        check({tag, "_play"},  32'(play_en),       32'(pe));
        check({tag, "_cd"},    32'(countdown_out), 32'(cd));
        check({tag, "_lives"}, 32'(lives_out),     32'(lv));
    endtask

    initial begin
        rst       = 1'b1;
        vblnk_in  = 1'b1;
        start_btn = 1'b0;
        hit       = 1'b0;

        // Reset values while reset is held
        #23;
        check_outputs("rst", 2'd0, 1'b0, 2'd0, 2'd3);
        check("rst_tick",  32'(frame_tick), 0);
        check("rst_flash", 32'(flash_out),  0);

        // Release with vblnk already high: no tick
        @(negedge pclk) rst = 1'b0;
        repeat (5) @(negedge pclk);
        check("no_tick_after_rst", 32'(tick_cnt), 0);

        // Three idle frames stay in MENU, one tick each
        repeat (3) frame();
        check("idle_ticks", 32'(tick_cnt), 3);
        check_outputs("idle", 2'd0, 1'b0, 2'd0, 2'd3);

        // Start pulse mid-frame -> COUNTDOWN 3
        pulse_start();
        frame();
        check_outputs("cd3", 2'd1, 1'b0, 2'd3, 2'd3);
        repeat (4) frame();
        check_outputs("cd2", 2'd1, 1'b0, 2'd2, 2'd3);
        repeat (4) frame();
        check_outputs("cd1", 2'd1, 1'b0, 2'd1, 2'd3);
        repeat (3) frame();
        check_outputs("cd1_last", 2'd1, 1'b0, 2'd1, 2'd3);
        frame();
        check_outputs("play", 2'd2, 1'b1, 2'd0, 2'd3);

        // First hit
        pulse_hit();
        frame();
`ifdef HIT_FLASH_EN
        check_outputs("hit1", 2'd2, 1'b0, 2'd0, 2'd2);
        check("hit1_flash", 32'(flash_out), 0);
        for (int k = 1; k <= 7; k++) begin
            frame();
            check($sformatf("flash_%0d", k), 32'(flash_out), (k >= 4) ? 1 : 0);
            check($sformatf("flash_play_%0d", k), 32'(play_en), 0);
        end
        frame();
        check_outputs("flash_exit", 2'd2, 1'b1, 2'd0, 2'd2);
        check("flash_exit_flash", 32'(flash_out), 0);
`else
        check_outputs("hit1", 2'd2, 1'b1, 2'd0, 2'd2);
        check("hit1_flash", 32'(flash_out), 0);
`endif

        // Hit and start on the same pclk: lives drop, no restart
        @(negedge pclk) begin hit = 1'b1; start_btn = 1'b1; end
        @(negedge pclk) begin hit = 1'b0; start_btn = 1'b0; end
        frame();
`ifdef HIT_FLASH_EN
        check_outputs("hit_start", 2'd2, 1'b0, 2'd0, 2'd1);
        repeat (8) frame();
        check_outputs("hit_start_back", 2'd2, 1'b1, 2'd0, 2'd1);
`else
        check_outputs("hit_start", 2'd2, 1'b1, 2'd0, 2'd1);
`endif

        // Hit on the frame_tick cycle is processed one frame later
        frame_hit_on_tick();
        check_outputs("hit_on_tick", 2'd2, 1'b1, 2'd0, 2'd1);
        frame();
        check_outputs("gameover", 2'd3, 1'b0, 2'd0, 2'd0);
        frame();
        check_outputs("gameover_hold", 2'd3, 1'b0, 2'd0, 2'd0);

        // Restart from GAMEOVER
        pulse_start();
        frame();
        check_outputs("restart", 2'd1, 1'b0, 2'd3, 2'd3);
        repeat (2) frame();
        check_outputs("restart_cd", 2'd1, 1'b0, 2'd3, 2'd3);

        // Asynchronous reset mid-COUNTDOWN, between clock edges
        @(negedge pclk);
        #1 rst = 1'b1;
        #1;
        check_outputs("async_rst", 2'd0, 1'b0, 2'd0, 2'd3);
        check("async_rst_tick",  32'(frame_tick), 0);
        check("async_rst_flash", 32'(flash_out),  0);
        @(negedge pclk) rst = 1'b0;

        // Back in MENU; a frame without start stays there
        frame();
        check_outputs("post_rst", 2'd0, 1'b0, 2'd0, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, frames per countdown second (2..63).
REQ-002 Parameter COUNT_SECONDS, default 3, countdown length in seconds (1..3).
REQ-003 Parameter LIVES, default 3, lives loaded at game start (1..3).
REQ-004 Parameter FLASH_FRAMES, default 32, HIT_FLASH duration in frames (1..63).
REQ-005 pclk  in  1  pixel clock, single clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 vblnk_in  in  1  vertical blanking from timing chain.
REQ-008 start_btn  in  1  debounced start request, level, sampled every pclk.
REQ-009 hit  in  1  player/obstacle collision pulse, sampled every pclk.
REQ-010 screen_sel  out  2  0=MENU, 1=COUNTDOWN, 2=PLAY (also HIT_FLASH), 3=GAMEOVER; drives background/overlay mux.
REQ-011 play_en  out  1  high only in PLAY; enables player/obstacle movement.
REQ-012 countdown_out  out  2  seconds remaining in COUNTDOWN, else 0.
REQ-013 lives_out  out  2  current lives.
REQ-014 frame_tick  out  1  one-pclk pulse per frame.
REQ-015 flash_out  out  1  boundary blink control for the arena border (white when 0, red when 1).

Function
REQ-016 frame_tick SHALL assert for one pclk on the cycle after vblnk_in rises (registered previous value, compare 0->1).
REQ-017 start_btn and hit SHALL each be captured into sticky flags on any pclk and cleared on the cycle frame_tick is high; a flag set in that same cycle SHALL survive into the next frame.
REQ-018 All state, counter and output updates except frame_tick SHALL occur only on frame_tick cycles, using flag values; outputs registered, valid 1 pclk after frame_tick.
REQ-019 States: MENU, COUNTDOWN, PLAY, HIT_FLASH, GAMEOVER.
REQ-020 MENU: start flag -> COUNTDOWN, frame counter=0, countdown_out=COUNT_SECONDS, lives_out=LIVES.
REQ-021 COUNTDOWN: 6-bit frame counter increments per tick; at FRAMES_PER_SEC-1 wraps to 0 and countdown_out decrements; when decrementing from 1 -> PLAY, countdown_out=0; start flag ignored.
REQ-022 PLAY: hit flag with lives_out>1 -> decrement lives, go to HIT_FLASH (or stay PLAY, see REQ-029); hit flag with lives_out==1 -> lives_out=0, GAMEOVER.
REQ-023 PLAY with hit and start flags both set: hit processed, start discarded.
REQ-024 HIT_FLASH: play_en=0; frame counter counts FLASH_FRAMES ticks then -> PLAY, counter=0; flash_out=counter bit 2 (toggle every 4 frames), 0 on exit; hit flags discarded.
REQ-025 GAMEOVER: start flag -> COUNTDOWN as in REQ-020; lives_out held at 0 until then.
REQ-026 Illegal state encoding SHALL return to MENU on next frame_tick with reset output values.

Reset
REQ-027 On rst high, immediately (asynchronous): state=MENU, screen_sel=0, play_en=0, countdown_out=0, lives_out=LIVES, frame_tick=0, flash_out=0, flags and frame counter cleared, vblnk history=1 (no tick on first frame after reset unless vblnk falls and rises).
REQ-028 rst mid-COUNTDOWN or mid-HIT_FLASH SHALL abandon the sequence; no output glitch beyond reset values.

Configuration
REQ-029 Macro HIT_FLASH_EN: defined -> HIT_FLASH state compiled in per REQ-022/024; undefined -> HIT_FLASH absent, non-fatal hit decrements lives and stays in PLAY with play_en=1, flash_out tied 0.

Verification (FRAMES_PER_SEC=4, COUNT_SECONDS=3, LIVES=3, FLASH_FRAMES=8)
REQ-030 Reset, 3 frames no input -> screen_sel=0, lives_out=3, play_en=0, one frame_tick per vblnk rise after first.
REQ-031 start_btn 1-pclk pulse mid-frame in MENU -> next tick screen_sel=1, countdown_out=3; 2,1 after 4 and 8 more ticks; PLAY, play_en=1, countdown_out=0 after 12.
REQ-032 hit pulse in PLAY (HIT_FLASH_EN) -> lives_out=2, play_en=0, flash_out toggles every 4 ticks, PLAY after 8 ticks; without macro -> lives_out=2, play_en stays 1.
REQ-033 Three hits in PLAY -> lives_out=0, screen_sel=3; start pulse -> screen_sel=1, lives_out=3.
REQ-034 hit and start_btn same pclk in PLAY -> lives_out decrements, no restart; hit on same pclk as frame_tick -> processed next frame.
REQ-035 rst asserted mid-COUNTDOWN between pclk edges -> outputs at reset values before next pclk edge.
